pipe_csel_adder: RTL and testbench

Parametrised, pipelined segmented adder/subtractor, the next generation of the team's fixed 16-bit adder. Operands split into SEG-bit segments; one segment is resolved per pipeline stage, with the carry registered between stages. A valid/ready handshake on both sides gives full throughput of one result per cycle and lossless backpressure. It sits between operand producers and any datapath consumer needing a WIDTH-bit sum with carry-out.

---
 rtl/pipe_csel_adder_if.sv | 37 +++
 rtl/pipe_csel_adder.sv | 120 ++++++++++++
 tb/tb_pipe_csel_adder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_csel_adder_if.sv
// Operand/result handshake bundle for pipe_csel_adder.
// The ovf signal exists only when ADDER_OVF_EN is defined.
interface pipe_csel_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDER_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/pipe_csel_adder.sv
// Pipelined segmented adder/subtractor: one SEG-bit segment resolved per stage,
// valid/ready on both sides. Define ADDER_OVF_EN to add the signed-overflow output.
module pipe_csel_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    pipe_csel_adder_if.slave bus
);
    localparam int unsigned NSTG = WIDTH / SEG;
    localparam int unsigned SW   = SEG + 1;
    localparam int unsigned LAST = NSTG - 1;

    if (WIDTH % SEG != 0) begin : g_bad_cfg
        $error("pipe_csel_adder: SEG must divide WIDTH");
    end

    // Per-stage state: operands are kept right-shifted so the next slice sits at bit 0,
    // and the sum is shifted in from the top so it lands aligned after the last stage.
    logic [NSTG-1:0]            r_vld;
    logic [NSTG-1:0]            r_cy;
    logic [NSTG-1:0][WIDTH-1:0] r_sum;
    logic [NSTG-1:0][WIDTH-1:0] r_a;
    logic [NSTG-1:0][WIDTH-1:0] r_b;

    logic [NSTG:0]              w_adv;
    logic [NSTG-1:0]            w_vin;
    logic [NSTG-1:0]            w_cin;
    logic [NSTG-1:0][WIDTH-1:0] w_a_in;
    logic [NSTG-1:0][WIDTH-1:0] w_b_in;
    logic [NSTG-1:0][WIDTH-1:0] w_sum_in;
    logic [NSTG-1:0][WIDTH-1:0] w_sum_nx;
    logic [NSTG-1:0][SW-1:0]    w_seg;
    logic [WIDTH-1:0]           w_b_eff;
    logic                       w_cin_eff;
    logic                       w_unused_ops;

    assign w_b_eff   = bus.sub ? ~bus.b : bus.b;
    assign w_cin_eff = bus.sub | bus.cin;

    // Stall chain: a stage moves when empty or when its successor moves.
    always_comb begin
        w_adv       = '0;
        w_adv[NSTG] = bus.out_ready;
        for (int k = NSTG - 1; k >= 0; k--) begin
            w_adv[k] = !r_vld[k] || w_adv[k+1];
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        if (k == 0) begin : g_head
            assign w_vin[k]    = bus.in_valid;
            assign w_cin[k]    = w_cin_eff;
            assign w_a_in[k]   = bus.a;
            assign w_b_in[k]   = w_b_eff;
            assign w_sum_in[k] = '0;
        end else begin : g_body
            assign w_vin[k]    = r_vld[k-1];
            assign w_cin[k]    = r_cy[k-1];
            assign w_a_in[k]   = r_a[k-1];
            assign w_b_in[k]   = r_b[k-1];
            assign w_sum_in[k] = r_sum[k-1];
        end

        assign w_seg[k]    = SW'(w_a_in[k][SEG-1:0]) + SW'(w_b_in[k][SEG-1:0]) + SW'(w_cin[k]);
        assign w_sum_nx[k] = (w_sum_in[k] >> SEG) | (WIDTH'(w_seg[k][SEG-1:0]) << (WIDTH - SEG));
    end

    // Stage registers; data only loads when a valid transaction moves in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_cy  <= '0;
            r_sum <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                if (w_adv[k]) begin
                    r_vld[k] <= w_vin[k];
                    if (w_vin[k]) begin
                        r_cy[k]  <= w_seg[k][SEG];
                        r_sum[k] <= w_sum_nx[k];
                        r_a[k]   <= w_a_in[k] >> SEG;
                        r_b[k]   <= w_b_in[k] >> SEG;
                    end
                end
            end
        end
    end

    // The last stage has no successor to hand operands to.
    assign w_unused_ops = ^{r_a[LAST], r_b[LAST]};

`ifdef ADDER_OVF_EN
    logic r_ovf;
    logic w_ovf_nx;

    // Carry into the MSB is a^b^sum at that bit; overflow is that XOR carry-out.
    assign w_ovf_nx = w_a_in[LAST][SEG-1] ^ w_b_in[LAST][SEG-1]
                    ^ w_seg[LAST][SEG-1]  ^ w_seg[LAST][SEG];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_adv[LAST] && w_vin[LAST]) begin
            r_ovf <= w_ovf_nx;
        end
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.in_ready  = !rst && w_adv[0];
    assign bus.out_valid = r_vld[LAST];
    assign bus.sum       = r_sum[LAST];
    assign bus.cout      = r_cy[LAST];

endmodule

// File: tb/tb_pipe_csel_adder.sv
// Directed self-checking bench for pipe_csel_adder (WIDTH=16, SEG=4).
// Checks ovf as well when ADDER_OVF_EN is defined.
module tb_pipe_csel_adder;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned SEG   = 4;
    localparam int unsigned NSTG  = WIDTH / SEG;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    pipe_csel_adder_if #(.WIDTH(WIDTH)) bus ();
    pipe_csel_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic s);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
        bus.sub      = s;
    endtask

    // Single transaction through an empty pipe; checks latency and result.
    task automatic one_shot(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic c, input logic s,
                            input logic [15:0] exp_sum, input logic exp_cout);
        set_in(1'b1, a, b, c, s);
        #1;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_early0"}, 32'(bus.out_valid), 32'd0);
        for (int i = 1; i < int'(NSTG) - 1; i++) begin
            step();
            chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
        end
        step();
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
`ifdef ADDER_OVF_EN
        begin
            logic [15:0] be;
            be = s ? ~b : b;
            chk({tag, "_ovf"}, 32'(bus.ovf),
                32'((a[15] == be[15]) && (exp_sum[15] != a[15])));
        end
`endif
        step();
        chk({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_q[$];
        logic [15:0] held;
        int          k;
        int          got;
        int          gaps;
        int          stale;
        bit          seen;

        rst           = 1'b1;
        bus.out_ready = 1'b1;
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
`ifdef ADDER_OVF_EN
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(bus.in_ready), 32'd1);
        step();

        one_shot("add_1_1",    16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);
        one_shot("add_ffff",   16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);
        one_shot("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0);
        one_shot("sub_5_7",    16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
        one_shot("sub_7_5",    16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
        one_shot("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1);

        // Back-to-back stream, out_ready held high.
        k = 1; got = 0; gaps = 0; seen = 0;
        set_in(1'b1, 16'd1, 16'd1, 1'b0, 1'b0);
        for (int c = 0; c < 200 && got < 48; c++) begin
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("stream_extra", 32'd1, 32'd0);
                else chk("stream_sum", 32'(bus.sum), 32'(exp_q.pop_front()));
                got++;
                seen = 1;
            end else if (seen) begin
                gaps++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(16'(2 * k));
                k++;
            end
            step();
            if (k > 48) bus.in_valid = 1'b0;
            else begin
                bus.a = 16'(k);
                bus.b = 16'(k);
            end
        end
        chk("stream_count", 32'(got), 32'd48);
        chk("stream_gaps", 32'(gaps), 32'd0);

        // Backpressure: out_ready low for cycles 10..15 of a 24-pair stream.
        exp_q.delete();
        k = 1; got = 0; held = '0;
        set_in(1'b1, 16'd1, 16'd1, 1'b0, 1'b0);
        for (int c = 0; c < 200 && got < 24; c++) begin
            bus.out_ready = (c < 10 || c >= 16);
            #1;
            if (c == 10) held = bus.sum;
            if (c > 10 && c < 16) begin
                chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
                chk("bp_hold_sum", 32'(bus.sum), 32'(held));
            end
            if (c == 15) begin
                chk("bp_occupancy", 32'(k - 1 - got), 32'd4);
                chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            end
            if (c == 16) chk("bp_in_ready_rise", 32'(bus.in_ready), 32'd1);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("bp_extra", 32'd1, 32'd0);
                else chk("bp_sum", 32'(bus.sum), 32'(exp_q.pop_front()));
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(16'(2 * k));
                k++;
            end
            step();
            if (k > 24) bus.in_valid = 1'b0;
            else begin
                bus.a = 16'(k);
                bus.b = 16'(k);
            end
        end
        chk("bp_count", 32'(got), 32'd24);
        bus.out_ready = 1'b1;

        // Reset with three pairs in flight.
        set_in(1'b1, 16'h0010, 16'h0010, 1'b0, 1'b0);
        step();
        bus.a = 16'h0020;
        step();
        bus.a = 16'h0030;
        step();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_sum", 32'(bus.sum), 32'd0);
        chk("midrst_cout", 32'(bus.cout), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_ready_after", 32'(bus.in_ready), 32'd1);
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.out_valid !== 1'b0) stale++;
        end
        chk("midrst_no_stale", 32'(stale), 32'd0);

        one_shot("post_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
